// File: rtl/bcd_mod_counter_if.sv
// Bundle of control, load/compare and status signals for one bcd_mod_counter stage.
//   master : drives cen/dir/inc/dec/clr/load, load digits and compare digits;
//            observes tens/ones, co/bo, match and load_err.
//   slave  : the counter itself (mirror of master).
interface bcd_mod_counter_if;
  logic       cen;
  logic       dir;
  logic       inc;
  logic       dec;
  logic       clr;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic [3:0] cmp_tens;
  logic [3:0] cmp_ones;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       co;
  logic       bo;
  logic       match;
  logic       load_err;

  modport master (
    output cen, dir, inc, dec, clr, load, load_tens, load_ones, cmp_tens, cmp_ones,
    input  tens, ones, co, bo, match, load_err
  );

  modport slave (
    input  cen, dir, inc, dec, clr, load, load_tens, load_ones, cmp_tens, cmp_ones,
    output tens, ones, co, bo, match, load_err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MOD counter with cascade carry/borrow, manual stepping,
// synchronous clear, validated parallel load and a BCD compare output.
//   clk    : rising-edge clock
//   n_rst  : synchronous active-low reset (count <- INIT, load_err <- 0)
//   bus    : slave side of bcd_mod_counter_if
//            cen/dir   cascade enable and direction (0 up, 1 down)
//            inc/dec   manual single steps (ignored while cen=1)
//            clr       clear to INIT; load + load_tens/load_ones parallel load
//            tens/ones registered digits; co/bo combinational cascade outputs
//            match     count equals cmp_tens/cmp_ones; load_err one-cycle reject flag
module bcd_mod_counter #(
  parameter int unsigned MOD  = 60,
  parameter int unsigned INIT = 0
) (
  input logic             clk,
  input logic             n_rst,
  bcd_mod_counter_if.slave bus
);

  localparam logic [3:0] MAX_T  = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_O  = 4'((MOD - 1) % 10);
  localparam logic [3:0] INIT_T = 4'(INIT / 10);
  localparam logic [3:0] INIT_O = 4'(INIT % 10);

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN
  } step_t;

  logic [3:0] tens_q, ones_q, tens_nx, ones_nx;
  logic       load_err_q, load_err_nx;
  logic       at_max, at_zero, load_valid;
  step_t      step;

  assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Digit-wise compare against MOD-1 avoids a binary conversion of the load value.
  assign load_valid = (bus.load_tens <= 4'd9) && (bus.load_ones <= 4'd9) &&
                      ((bus.load_tens < MAX_T) ||
                       ((bus.load_tens == MAX_T) && (bus.load_ones <= MAX_O)));

  always_comb begin
    step = STEP_HOLD;
    if (bus.cen)
      step = bus.dir ? STEP_DOWN : STEP_UP;
    else if (bus.inc && !bus.dec)
      step = STEP_UP;
    else if (bus.dec && !bus.inc)
      step = STEP_DOWN;
  end

  always_comb begin
    tens_nx     = tens_q;
    ones_nx     = ones_q;
    load_err_nx = 1'b0;
    if (bus.clr) begin
      tens_nx = INIT_T;
      ones_nx = INIT_O;
    end else if (bus.load) begin
      // A rejected load also suppresses any step in the same cycle.
      if (load_valid) begin
        tens_nx = bus.load_tens;
        ones_nx = bus.load_ones;
      end else begin
        load_err_nx = 1'b1;
      end
    end else begin
      unique case (step)
        STEP_UP: begin
          if (at_max) begin
            tens_nx = '0;
            ones_nx = '0;
          end else if (ones_q == 4'd9) begin
            tens_nx = tens_q + 4'd1;
            ones_nx = '0;
          end else begin
            ones_nx = ones_q + 4'd1;
          end
        end
        STEP_DOWN: begin
          if (at_zero) begin
            tens_nx = MAX_T;
            ones_nx = MAX_O;
          end else if (ones_q == 4'd0) begin
            tens_nx = tens_q - 4'd1;
            ones_nx = 4'd9;
          end else begin
            ones_nx = ones_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tens_q     <= INIT_T;
      ones_q     <= INIT_O;
      load_err_q <= 1'b0;
    end else begin
      tens_q     <= tens_nx;
      ones_q     <= ones_nx;
      load_err_q <= load_err_nx;
    end
  end

  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;
  assign bus.load_err = load_err_q;
  // Cascade outputs are gated by clr/load so a stage being rewritten never ripples.
  assign bus.co       = bus.cen && !bus.dir && at_max && !bus.clr && !bus.load;
  assign bus.bo       = bus.cen && bus.dir && at_zero && !bus.clr && !bus.load;
  // Digits are always below MOD, so a compare value of MOD or more cannot match.
  assign bus.match    = (tens_q == bus.cmp_tens) && (ones_q == bus.cmp_ones);

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;
  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_mod_counter_if if_a ();   // modulus 60, reset value 12
  bcd_mod_counter_if if_b ();   // modulus 24, reset value 0
  bcd_mod_counter_if if_lo ();  // cascade low stage, modulus 60
  bcd_mod_counter_if if_hi ();  // cascade high stage, modulus 60

  bcd_mod_counter #(.MOD(60), .INIT(12)) dut_a  (.clk(clk), .n_rst(n_rst), .bus(if_a));
  bcd_mod_counter #(.MOD(24), .INIT(0))  dut_b  (.clk(clk), .n_rst(n_rst), .bus(if_b));
  bcd_mod_counter #(.MOD(60), .INIT(0))  dut_lo (.clk(clk), .n_rst(n_rst), .bus(if_lo));
  bcd_mod_counter #(.MOD(60), .INIT(0))  dut_hi (.clk(clk), .n_rst(n_rst), .bus(if_hi));

  assign if_hi.cen = if_lo.co | if_lo.bo;
  assign if_hi.dir = if_lo.dir;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    {if_a.cen, if_a.dir, if_a.inc, if_a.dec, if_a.clr, if_a.load} = '0;
    {if_b.cen, if_b.dir, if_b.inc, if_b.dec, if_b.clr, if_b.load} = '0;
    {if_lo.cen, if_lo.dir, if_lo.inc, if_lo.dec, if_lo.clr, if_lo.load} = '0;
    {if_hi.inc, if_hi.dec, if_hi.clr, if_hi.load} = '0;
    {if_a.load_tens, if_a.load_ones, if_a.cmp_tens, if_a.cmp_ones} = '0;
    {if_b.load_tens, if_b.load_ones, if_b.cmp_tens, if_b.cmp_ones} = '0;
    {if_lo.load_tens, if_lo.load_ones, if_lo.cmp_tens, if_lo.cmp_ones} = '0;
    {if_hi.load_tens, if_hi.load_ones, if_hi.cmp_tens, if_hi.cmp_ones} = '0;
  endtask

  task automatic test_reset();
    idle_all();
    n_rst = 1'b0;
    if_b.load = 1'b1; if_b.load_tens = 4'd9; if_b.load_ones = 4'd9;
    tick();
    n_rst = 1'b1;
    idle_all();
    if_a.cmp_tens = 4'd1; if_a.cmp_ones = 4'd2;
    if_b.cen = 1'b1; if_b.dir = 1'b1;
    #1;
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h12) begin
      errors++; $display("FAIL reset_a_value got %h want 12", {if_a.tens, if_a.ones});
    end
    checks++;
    if (if_a.load_err !== 1'b0 || if_b.load_err !== 1'b0) begin
      errors++; $display("FAIL reset_load_err got %b%b want 00", if_a.load_err, if_b.load_err);
    end
    checks++;
    if (if_a.match !== 1'b1) begin
      errors++; $display("FAIL reset_match got %b want 1", if_a.match);
    end
    checks++;
    if ({if_b.tens, if_b.ones} !== 8'h00 || if_b.bo !== 1'b1) begin
      errors++; $display("FAIL reset_b got %h bo=%b want 00 bo=1", {if_b.tens, if_b.ones}, if_b.bo);
    end
    idle_all();
  endtask

  task automatic test_count_up();
    int unsigned v;
    if_a.load = 1'b1; if_a.load_tens = 4'd0; if_a.load_ones = 4'd0;
    tick();
    idle_all();
    if_a.cen = 1'b1; if_a.dir = 1'b0;
    for (int unsigned i = 0; i <= 60; i++) begin
      v = i % 60;
      #1;
      checks++;
      if (if_a.tens !== 4'(v / 10) || if_a.ones !== 4'(v % 10) || if_a.co !== (v == 59)) begin
        errors++;
        $display("FAIL count_up step %0d got %h co=%b want %0d co=%b",
                 i, {if_a.tens, if_a.ones}, if_a.co, v, (v == 59));
      end
      tick();
    end
    idle_all();
  endtask

  task automatic test_count_down();
    if_a.load = 1'b1; if_a.load_tens = 4'd0; if_a.load_ones = 4'd0;
    tick();
    idle_all();
    if_a.cen = 1'b1; if_a.dir = 1'b1;
    #1;
    checks++;
    if (if_a.bo !== 1'b1 || if_a.co !== 1'b0) begin
      errors++; $display("FAIL down_bo_at_00 got bo=%b co=%b want bo=1 co=0", if_a.bo, if_a.co);
    end
    tick();
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h59 || if_a.bo !== 1'b0) begin
      errors++; $display("FAIL down_wrap got %h bo=%b want 59 bo=0", {if_a.tens, if_a.ones}, if_a.bo);
    end
    idle_all();
    if_a.load = 1'b1; if_a.load_tens = 4'd1; if_a.load_ones = 4'd0;
    tick();
    idle_all();
    if_a.cen = 1'b1; if_a.dir = 1'b1;
    tick();
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h09) begin
      errors++; $display("FAIL down_borrow_digit got %h want 09", {if_a.tens, if_a.ones});
    end
    idle_all();
  endtask

  task automatic test_load();
    if_b.load = 1'b1; if_b.load_tens = 4'd2; if_b.load_ones = 4'd3;
    tick();
    checks++;
    if ({if_b.tens, if_b.ones} !== 8'h23 || if_b.load_err !== 1'b0) begin
      errors++; $display("FAIL load_23 got %h err=%b want 23 err=0", {if_b.tens, if_b.ones}, if_b.load_err);
    end
    idle_all();
    if_b.inc = 1'b1;
    tick();
    checks++;
    if ({if_b.tens, if_b.ones} !== 8'h00) begin
      errors++; $display("FAIL inc_wrap_24 got %h want 00", {if_b.tens, if_b.ones});
    end
    // invalid 24 with cen high: no load, no step
    idle_all();
    if_b.load = 1'b1; if_b.load_tens = 4'd2; if_b.load_ones = 4'd4; if_b.cen = 1'b1;
    #1;
    checks++;
    if (if_b.co !== 1'b0) begin
      errors++; $display("FAIL load_co got %b want 0", if_b.co);
    end
    tick();
    checks++;
    if ({if_b.tens, if_b.ones} !== 8'h00 || if_b.load_err !== 1'b1) begin
      errors++; $display("FAIL load_24_reject got %h err=%b want 00 err=1", {if_b.tens, if_b.ones}, if_b.load_err);
    end
    idle_all();
    tick();
    checks++;
    if (if_b.load_err !== 1'b0) begin
      errors++; $display("FAIL load_err_one_cycle got %b want 0", if_b.load_err);
    end
    if_b.load = 1'b1; if_b.load_tens = 4'd1; if_b.load_ones = 4'hA;
    tick();
    checks++;
    if ({if_b.tens, if_b.ones} !== 8'h00 || if_b.load_err !== 1'b1) begin
      errors++; $display("FAIL load_1A_reject got %h err=%b want 00 err=1", {if_b.tens, if_b.ones}, if_b.load_err);
    end
    // second consecutive invalid load keeps the flag high
    if_b.load_tens = 4'd9; if_b.load_ones = 4'd9;
    tick();
    checks++;
    if (if_b.load_err !== 1'b1) begin
      errors++; $display("FAIL load_err_back_to_back got %b want 1", if_b.load_err);
    end
    idle_all();
    tick();
    checks++;
    if (if_b.load_err !== 1'b0) begin
      errors++; $display("FAIL load_err_clears got %b want 0", if_b.load_err);
    end
  endtask

  task automatic test_priority();
    if_a.load = 1'b1; if_a.load_tens = 4'd5; if_a.load_ones = 4'd9;
    tick();
    if_a.load_tens = 4'd0; if_a.load_ones = 4'd5; if_a.cen = 1'b1;
    #1;
    checks++;
    if (if_a.co !== 1'b0) begin
      errors++; $display("FAIL load_masks_co got %b want 0", if_a.co);
    end
    tick();
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h05) begin
      errors++; $display("FAIL load_over_step got %h want 05", {if_a.tens, if_a.ones});
    end
    if_a.load_tens = 4'd1; if_a.load_ones = 4'd7; if_a.cen = 1'b0;
    tick();
    if_a.clr = 1'b1; if_a.load = 1'b1; if_a.load_tens = 4'd9; if_a.load_ones = 4'd9;
    if_a.cen = 1'b1; if_a.inc = 1'b1;
    #1;
    checks++;
    if (if_a.co !== 1'b0) begin
      errors++; $display("FAIL clr_co got %b want 0", if_a.co);
    end
    tick();
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h12 || if_a.load_err !== 1'b0) begin
      errors++; $display("FAIL clr_priority got %h err=%b want 12 err=0", {if_a.tens, if_a.ones}, if_a.load_err);
    end
    idle_all();
  endtask

  task automatic test_step_select();
    if_a.load = 1'b1; if_a.load_tens = 4'd0; if_a.load_ones = 4'd5;
    tick();
    idle_all();
    if_a.inc = 1'b1; if_a.dec = 1'b1;
    tick();
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h05) begin
      errors++; $display("FAIL inc_dec_hold got %h want 05", {if_a.tens, if_a.ones});
    end
    if_a.inc = 1'b0; if_a.cen = 1'b1;
    tick();
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h06) begin
      errors++; $display("FAIL cen_over_dec got %h want 06", {if_a.tens, if_a.ones});
    end
    idle_all();
    if_a.load = 1'b1; if_a.load_tens = 4'd5; if_a.load_ones = 4'd9;
    tick();
    idle_all();
    if_a.inc = 1'b1;
    #1;
    checks++;
    if (if_a.co !== 1'b0) begin
      errors++; $display("FAIL inc_no_co got %b want 0", if_a.co);
    end
    tick();
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h00) begin
      errors++; $display("FAIL inc_wrap got %h want 00", {if_a.tens, if_a.ones});
    end
    if_a.inc = 1'b0; if_a.dec = 1'b1;
    #1;
    checks++;
    if (if_a.bo !== 1'b0) begin
      errors++; $display("FAIL dec_no_bo got %b want 0", if_a.bo);
    end
    tick();
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h59) begin
      errors++; $display("FAIL dec_wrap got %h want 59", {if_a.tens, if_a.ones});
    end
    idle_all();
  endtask

  task automatic test_cascade();
    if_lo.load = 1'b1; if_lo.load_tens = 4'd5; if_lo.load_ones = 4'd9;
    if_hi.load = 1'b1; if_hi.load_tens = 4'd5; if_hi.load_ones = 4'd9;
    tick();
    idle_all();
    if_lo.cen = 1'b1; if_lo.dir = 1'b0;
    #1;
    checks++;
    if (if_lo.co !== 1'b1 || if_hi.co !== 1'b1) begin
      errors++; $display("FAIL cascade_co got lo=%b hi=%b want 1 1", if_lo.co, if_hi.co);
    end
    tick();
    checks++;
    if ({if_hi.tens, if_hi.ones, if_lo.tens, if_lo.ones} !== 16'h0000) begin
      errors++; $display("FAIL cascade_up got %h want 0000", {if_hi.tens, if_hi.ones, if_lo.tens, if_lo.ones});
    end
    if_lo.dir = 1'b1;
    #1;
    checks++;
    if (if_lo.bo !== 1'b1 || if_hi.bo !== 1'b1) begin
      errors++; $display("FAIL cascade_bo got lo=%b hi=%b want 1 1", if_lo.bo, if_hi.bo);
    end
    tick();
    checks++;
    if ({if_hi.tens, if_hi.ones, if_lo.tens, if_lo.ones} !== 16'h5959) begin
      errors++; $display("FAIL cascade_down got %h want 5959", {if_hi.tens, if_hi.ones, if_lo.tens, if_lo.ones});
    end
    if_lo.dir = 1'b0; if_lo.cen = 1'b1;
    tick();
    tick();
    checks++;
    if ({if_hi.tens, if_hi.ones, if_lo.tens, if_lo.ones} !== 16'h0001) begin
      errors++; $display("FAIL cascade_cont got %h want 0001", {if_hi.tens, if_hi.ones, if_lo.tens, if_lo.ones});
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    if_b.load = 1'b1; if_b.load_tens = 4'd1; if_b.load_ones = 4'd5;
    tick();
    if_b.load_tens = 4'd3; if_b.load_ones = 4'd0;
    tick();
    checks++;
    if (if_b.load_err !== 1'b1 || {if_b.tens, if_b.ones} !== 8'h15) begin
      errors++; $display("FAIL pre_reset got %h err=%b want 15 err=1", {if_b.tens, if_b.ones}, if_b.load_err);
    end
    n_rst = 1'b0; if_b.cen = 1'b1;
    tick();
    n_rst = 1'b1;
    idle_all();
    if_b.cmp_tens = 4'd0; if_b.cmp_ones = 4'd0;
    #1;
    checks++;
    if ({if_b.tens, if_b.ones} !== 8'h00 || if_b.load_err !== 1'b0 || if_b.match !== 1'b1) begin
      errors++; $display("FAIL reset_mid got %h err=%b match=%b want 00 err=0 match=1",
                         {if_b.tens, if_b.ones}, if_b.load_err, if_b.match);
    end
    checks++;
    if ({if_a.tens, if_a.ones} !== 8'h12) begin
      errors++; $display("FAIL reset_mid_a got %h want 12", {if_a.tens, if_a.ones});
    end
    if_a.cmp_tens = 4'd1; if_a.cmp_ones = 4'd3;
    #1;
    checks++;
    if (if_a.match !== 1'b0) begin
      errors++; $display("FAIL match_ne got %b want 0", if_a.match);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    idle_all();
    tick();
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_priority();
    test_step_select();
    test_cascade();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter MOD, default 60: counter modulus; the count sequence SHALL be 0..MOD-1; legal range 2..100.
REQ-002 Parameter INIT, default 0: value after reset and after CLR; legal range 0..MOD-1.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 n_rst  input  1  synchronous, active-low reset.
REQ-005 cen  input  1  cascade count enable; steps the counter in direction dir.
REQ-006 dir  input  1  cascade direction: 0 = up, 1 = down.
REQ-007 inc  input  1  manual single-step up.
REQ-008 dec  input  1  manual single-step down.
REQ-009 clr  input  1  synchronous clear to INIT.
REQ-010 load  input  1  parallel load strobe.
REQ-011 load_tens, load_ones  input  4 each  BCD value to load.
REQ-012 cmp_tens, cmp_ones  input  4 each  BCD compare value.
REQ-013 tens, ones  output  4 each  registered BCD count digits.
REQ-014 co  output  1  combinational cascade carry.
REQ-015 bo  output  1  combinational cascade borrow.
REQ-016 match  output  1  combinational: high when {tens,ones} equals {cmp_tens,cmp_ones}.
REQ-017 load_err  output  1  registered one-cycle pulse flagging a rejected load.

Function
REQ-018 Count value V = 10*tens + ones; each digit SHALL be 0..9 and V SHALL stay below MOD in every cycle after reset.
REQ-019 Per-edge priority SHALL be: n_rst low > clr > load > step > hold.
REQ-020 Step selection: if cen=1, step up when dir=0 and down when dir=1, ignoring inc/dec; if cen=0, inc&!dec steps up, dec&!inc steps down, and inc&dec holds.
REQ-021 Up step: V=MOD-1 -> 0; otherwise V+1, with ones 9 -> 0 and tens incremented.
REQ-022 Down step: V=0 -> MOD-1; otherwise V-1, with ones 0 -> 9 and tens decremented.
REQ-023 co SHALL equal cen & !dir & (V==MOD-1); it is never asserted by inc.
REQ-024 bo SHALL equal cen & dir & (V==0); it is never asserted by dec.
REQ-025 co and bo SHALL be low during a cycle in which clr or load is asserted.
REQ-026 A load is valid when load_tens<=9, load_ones<=9 and 10*load_tens+load_ones<MOD; a valid load SHALL set V on the next edge.
REQ-027 An invalid load SHALL leave V unchanged, perform no step in that cycle, and pulse load_err high for exactly the following cycle.
REQ-028 load_err SHALL be low in every other cycle; back-to-back invalid loads SHALL hold it high continuously.
REQ-029 clr SHALL set V=INIT on the next edge regardless of load, cen, inc and dec.
REQ-030 Updates SHALL have single-cycle latency: the new digits are visible immediately after the edge.
REQ-031 Cascading: co/bo of stage k, driven to cen of stage k+1 with a shared dir, SHALL make the chain count as one multi-digit counter without extra latency.
REQ-032 match SHALL be purely combinational from the current digits and the cmp inputs; a cmp value of MOD or above never matches.

Reset
REQ-033 On an edge with n_rst=0: tens/ones SHALL be the INIT digits and load_err=0, overriding all other inputs.
REQ-034 A reset mid-operation (including during a load_err pulse) SHALL abort the operation; no carry, borrow or error effect SHALL persist past the reset edge.
REQ-035 co, bo and match SHALL follow the reset state combinationally from the first cycle after reset.

Verification
REQ-036 MOD=60, cen=1, dir=0 for 60 cycles from 0 -> sequence 00..59, 00; co high only while V=59.
REQ-037 MOD=60, V=00, cen=1, dir=1 -> next V=59; bo high in the V=00 cycle only; from V=10 a down step -> 09.
REQ-038 MOD=24, load 23 then inc -> V=23 then 00; load 24 -> V unchanged and load_err=1 for one cycle; load tens=1 ones=A -> rejected the same way.
REQ-039 clr, load and cen asserted together at V=17 -> next V=INIT; co=0; load_err=0.
REQ-040 inc&dec together -> hold; cen=1 with dec=1 and dir=0 -> up step; two instances cascaded with MOD=60 -> 59:59 + 1 -> 00:00 in one edge.
REQ-041 n_rst=0 asserted during load of an invalid value -> V=INIT and load_err=0 after the edge; match checked with cmp=INIT -> 1.
